// File: rtl/apb_master_nslv.sv
// APB master with NSLV one-hot selects.
// Takes read/write requests over a valid/ready handshake, runs one APB
// transfer per request (back-to-back when the next request is already
// waiting), and returns a one-cycle response pulse per request. Slave
// errors, out-of-range selects and wait-state timeouts are reported on
// the response.
module apb_master_nslv #(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int NSLV    = 4,
  parameter int SW      = 2,
  parameter int TIMEOUT = 15
) (
  input  logic            PCLK,
  input  logic            PRESET,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_write,
  input  logic [SW-1:0]   i_req_sel,
  input  logic [AW-1:0]   i_req_addr,
  input  logic [DW-1:0]   i_req_wdata,
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  output logic [NSLV-1:0] PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic            PREADY,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PSLVERR
);

  // The wait counter only has to reach TIMEOUT; at that value the transfer
  // either completes or is aborted, so it never needs to count further.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   wait_cnt, wait_cnt_d;
  // A bad select accepted on a completion cycle owes an error pulse on the
  // following cycle, since the completion pulse occupies the current one.
  logic            bad_pend, bad_pend_d;

  logic [NSLV-1:0] psel_d;
  logic            penable_d;
  logic            pwrite_d;
  logic [AW-1:0]   paddr_d;
  logic [DW-1:0]   pwdata_d;
  logic            rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_d;
  logic            rsp_err_d;
  logic            rsp_timeout_d;

  logic            accept;
  logic            sel_ok;
  logic            timeout_hit;

  assign o_req_ready = (state == S_IDLE) || ((state == S_ACCESS) && PREADY);
  assign accept      = i_req_valid && o_req_ready;
  assign sel_ok      = (32'(i_req_sel) < NSLV);
  assign timeout_hit = (TIMEOUT > 0) && (state == S_ACCESS) && !PREADY &&
                       (wait_cnt == CW'(TIMEOUT));

  // State and output registers; synchronous reset drops any transfer silently.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      bad_pend      <= 1'b0;
      PSEL          <= '0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PWDATA        <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      state         <= state_d;
      wait_cnt      <= wait_cnt_d;
      bad_pend      <= bad_pend_d;
      PSEL          <= psel_d;
      PENABLE       <= penable_d;
      PWRITE        <= pwrite_d;
      PADDR         <= paddr_d;
      PWDATA        <= pwdata_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_rdata   <= rsp_rdata_d;
      o_rsp_err     <= rsp_err_d;
      o_rsp_timeout <= rsp_timeout_d;
    end
  end

  // Next-state selection: IDLE -> SETUP -> ACCESS -> (SETUP | IDLE).
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (accept && sel_ok) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY)           state_d = (i_req_valid && sel_ok) ? S_SETUP : S_IDLE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered bus and response outputs.
  always_comb begin
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = o_rsp_rdata;
    rsp_err_d     = o_rsp_err;
    rsp_timeout_d = o_rsp_timeout;
    wait_cnt_d    = wait_cnt;
    bad_pend_d    = 1'b0;

    case (state)
      S_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        if (bad_pend || (accept && !sel_ok)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b0;
          // A fresh bad select behind a pending one gets its own pulse next.
          bad_pend_d    = bad_pend && accept && !sel_ok;
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (PREADY) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          bad_pend_d    = accept && !sel_ok;
        end else if (timeout_hit) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + CW'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase

    // Loading a request (from IDLE or back-to-back) overrides the bus outputs.
    if (accept && sel_ok) begin
      psel_d     = NSLV'(1) << i_req_sel;
      penable_d  = 1'b0;
      pwrite_d   = i_req_write;
      paddr_d    = i_req_addr;
      pwdata_d   = i_req_write ? i_req_wdata : '0;
      wait_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Bench for apb_master_nslv: a cycle table for the single, waited,
// back-to-back and bad-select transfers, then hand-written sequences for the
// timeout limit, completion on the limit cycle and reset mid-transfer.
module tb_apb_master_nslv;

  logic       pclk = 1'b0;
  logic       preset;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_sel;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic [3:0] psel;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;

  int checks = 0;
  int errors = 0;

  apb_master_nslv #(.DW(8), .AW(8), .NSLV(4), .SW(3), .TIMEOUT(15)) dut (
    .PCLK(pclk), .PRESET(preset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_sel(req_sel), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_rsp_timeout(rsp_timeout),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       preset, valid, write;
    logic [2:0] sel;
    logic [7:0] addr, wdata;
    logic       pready;
    logic [7:0] prdata;
    logic       pslverr;
    logic       e_ready;
    logic [3:0] e_psel;
    logic       e_pen, e_pwr;
    logic [7:0] e_paddr, e_pwdata;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_err, e_to;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(
    input logic preset_i, valid_i, write_i, input logic [2:0] sel_i,
    input logic [7:0] addr_i, wdata_i, input logic pready_i,
    input logic [7:0] prdata_i, input logic pslverr_i,
    input logic e_ready_i, input logic [3:0] e_psel_i, input logic e_pen_i, e_pwr_i,
    input logic [7:0] e_paddr_i, e_pwdata_i, input logic e_rv_i,
    input logic [7:0] e_rd_i, input logic e_err_i, e_to_i);
    vec_t v;
    v.preset = preset_i; v.valid = valid_i; v.write = write_i; v.sel = sel_i;
    v.addr = addr_i; v.wdata = wdata_i; v.pready = pready_i; v.prdata = prdata_i;
    v.pslverr = pslverr_i; v.e_ready = e_ready_i; v.e_psel = e_psel_i;
    v.e_pen = e_pen_i; v.e_pwr = e_pwr_i; v.e_paddr = e_paddr_i;
    v.e_pwdata = e_pwdata_i; v.e_rv = e_rv_i; v.e_rd = e_rd_i;
    v.e_err = e_err_i; v.e_to = e_to_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pr, v, w, input logic [2:0] s,
                       input logic [7:0] a, d, input logic rdy,
                       input logic [7:0] rd, input logic se);
    preset = pr; req_valid = v; req_write = w; req_sel = s;
    req_addr = a; req_wdata = d; pready = rdy; prdata = rd; pslverr = se;
  endtask

  // Checks all registered outputs in one go.
  task automatic check_outs(input string tag, input logic [3:0] ps, input logic pe, pw,
                            input logic [7:0] pa, pd, input logic rv,
                            input logic [7:0] rd, input logic er, to);
    check({tag, " psel"},    32'(psel),        32'(ps));
    check({tag, " penable"}, 32'(penable),     32'(pe));
    check({tag, " pwrite"},  32'(pwrite),      32'(pw));
    check({tag, " paddr"},   32'(paddr),       32'(pa));
    check({tag, " pwdata"},  32'(pwdata),      32'(pd));
    check({tag, " rsp_v"},   32'(rsp_valid),   32'(rv));
    check({tag, " rdata"},   32'(rsp_rdata),   32'(rd));
    check({tag, " err"},     32'(rsp_err),     32'(er));
    check({tag, " tmo"},     32'(rsp_timeout), 32'(to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        pr v w sel addr   wdata  rdy prdata se | rdy psel     pe pw paddr  pwdata rv rd     er to
    tbl[0]  = mk(0,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 1,4'b0000,0,0,8'h00,8'h00,0,8'h00,0,0);
    // single write, sel 2, zero wait
    tbl[1]  = mk(1,1,1,3'd2,8'h3C,8'hA5,1,8'h00,0, 1,4'b0100,0,1,8'h3C,8'hA5,0,8'h00,0,0);
    tbl[2]  = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 0,4'b0100,1,1,8'h3C,8'hA5,0,8'h00,0,0);
    tbl[3]  = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 1,4'b0000,0,1,8'h3C,8'hA5,1,8'h00,0,0);
    // read sel 0, three wait states, PSLVERR on completion
    tbl[4]  = mk(1,1,0,3'd0,8'h11,8'hFF,0,8'h00,0, 1,4'b0001,0,0,8'h11,8'h00,0,8'h00,0,0);
    tbl[5]  = mk(1,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 0,4'b0001,1,0,8'h11,8'h00,0,8'h00,0,0);
    tbl[6]  = mk(1,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 0,4'b0001,1,0,8'h11,8'h00,0,8'h00,0,0);
    tbl[7]  = mk(1,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 0,4'b0001,1,0,8'h11,8'h00,0,8'h00,0,0);
    tbl[8]  = mk(1,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 0,4'b0001,1,0,8'h11,8'h00,0,8'h00,0,0);
    tbl[9]  = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h5E,1, 1,4'b0000,0,0,8'h11,8'h00,1,8'h5E,1,0);
    tbl[10] = mk(1,0,0,3'd0,8'h00,8'h00,0,8'h00,0, 1,4'b0000,0,0,8'h11,8'h00,0,8'h5E,1,0);
    // back-to-back: write sel 1 then read sel 3
    tbl[11] = mk(1,1,1,3'd1,8'h20,8'h3C,1,8'h00,0, 1,4'b0010,0,1,8'h20,8'h3C,0,8'h5E,1,0);
    tbl[12] = mk(1,1,0,3'd3,8'h40,8'h77,1,8'h00,0, 0,4'b0010,1,1,8'h20,8'h3C,0,8'h5E,1,0);
    tbl[13] = mk(1,1,0,3'd3,8'h40,8'h77,1,8'h99,0, 1,4'b1000,0,0,8'h40,8'h00,1,8'h00,0,0);
    tbl[14] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'hAB,0, 0,4'b1000,1,0,8'h40,8'h00,0,8'h00,0,0);
    tbl[15] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'hAB,0, 1,4'b0000,0,0,8'h40,8'h00,1,8'hAB,0,0);
    // bad select from IDLE
    tbl[16] = mk(1,1,1,3'd5,8'h55,8'h66,1,8'h00,0, 1,4'b0000,0,0,8'h40,8'h00,1,8'h00,1,0);
    tbl[17] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 1,4'b0000,0,0,8'h40,8'h00,0,8'h00,1,0);
    // write sel 2, then bad select back-to-back on its completion
    tbl[18] = mk(1,1,1,3'd2,8'h0A,8'h0B,1,8'h00,0, 1,4'b0100,0,1,8'h0A,8'h0B,0,8'h00,1,0);
    tbl[19] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 0,4'b0100,1,1,8'h0A,8'h0B,0,8'h00,1,0);
    tbl[20] = mk(1,1,0,3'd6,8'h0C,8'h00,1,8'h00,0, 1,4'b0000,0,1,8'h0A,8'h0B,1,8'h00,0,0);
    tbl[21] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 1,4'b0000,0,1,8'h0A,8'h0B,1,8'h00,1,0);
    tbl[22] = mk(1,0,0,3'd0,8'h00,8'h00,1,8'h00,0, 1,4'b0000,0,1,8'h0A,8'h0B,0,8'h00,1,0);

    drive(0, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0);
    repeat (2) @(posedge pclk);

    for (int i = 0; i < 23; i++) begin
      @(negedge pclk);
      drive(tbl[i].preset, tbl[i].valid, tbl[i].write, tbl[i].sel, tbl[i].addr,
            tbl[i].wdata, tbl[i].pready, tbl[i].prdata, tbl[i].pslverr);
      #1 check($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      @(posedge pclk); #1;
      check_outs($sformatf("v%0d", i), tbl[i].e_psel, tbl[i].e_pen, tbl[i].e_pwr,
                 tbl[i].e_paddr, tbl[i].e_pwdata, tbl[i].e_rv, tbl[i].e_rd,
                 tbl[i].e_err, tbl[i].e_to);
    end

    // Timeout: PREADY held low, abort at the end of the 16th ACCESS cycle,
    // then the same transfer completing on the limit cycle.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge pclk);
      drive(1, 1, 0, 3'd1, 8'h33, 8'h00, 0, 8'hEE, 0);
      @(posedge pclk); #1;
      check($sformatf("to%0d setup psel", pass), 32'(psel), 32'h2);
      @(negedge pclk);
      drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'hEE, 0);
      @(posedge pclk); #1;
      for (int k = 1; k <= 16; k++) begin
        @(negedge pclk);
        if (k == 16 && pass == 1) drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h4D, 0);
        #1;
        if (k == 16)
          check($sformatf("to%0d limit ready", pass), 32'(req_ready), 32'(pass));
        @(posedge pclk); #1;
        if (k < 16)
          check($sformatf("to%0d wait k%0d", pass, k),
                32'({psel, penable, rsp_valid}), 32'({4'b0010, 1'b1, 1'b0}));
      end
      if (pass == 0)
        check_outs("to0 abort", 4'b0000, 0, 0, 8'h33, 8'h00, 1, 8'h00, 1, 1);
      else
        check_outs("to1 limit", 4'b0000, 0, 0, 8'h33, 8'h00, 1, 8'h4D, 0, 0);
      @(negedge pclk);
      drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0);
      @(posedge pclk); #1;
      check($sformatf("to%0d after rsp_v", pass), 32'(rsp_valid), 32'h0);
    end

    // Reset during an ACCESS wait state.
    @(negedge pclk);
    drive(1, 1, 1, 3'd3, 8'h70, 8'h12, 0, 8'h00, 0);
    @(posedge pclk);
    @(negedge pclk);
    drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0);
    repeat (3) @(posedge pclk);
    #1 check("rst pre penable", 32'(penable), 32'h1);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk); #1;
    check_outs("rst", 4'b0000, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    @(negedge pclk);
    drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 0);
    @(posedge pclk); #1;
    check("rst release rsp_v", 32'(rsp_valid), 32'h0);
    @(negedge pclk);
    drive(1, 1, 0, 3'd0, 8'h01, 8'h00, 1, 8'h42, 0);
    #1 check("post rst ready", 32'(req_ready), 32'h1);
    @(posedge pclk); #1;
    check_outs("post rst setup", 4'b0001, 0, 0, 8'h01, 8'h00, 0, 8'h00, 0, 0);
    @(negedge pclk);
    drive(1, 0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h42, 0);
    @(posedge pclk); #1;
    check("post rst access pen", 32'(penable), 32'h1);
    @(posedge pclk); #1;
    check_outs("post rst done", 4'b0000, 0, 0, 8'h01, 8'h00, 1, 8'h42, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
